// File: rtl/xor_stream_cipher.sv
// XOR stream cipher: each accepted word is XORed with the low bits of a Galois LFSR keystream.
// Optional XOR_STREAM_BYPASS_EN adds a BYPASS input that passes words through unencrypted.
module xor_stream_cipher #(
  parameter int WIDTH  = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [LFSR_W-1:0] SEED,
  input  logic              SEED_VLD,
  input  logic [WIDTH-1:0]  IN_DATA,
  input  logic              IN_VLD,
  output logic              IN_RDY,
  output logic [WIDTH-1:0]  OUT_DATA,
  output logic              OUT_VLD,
  input  logic              OUT_RDY,
`ifdef XOR_STREAM_BYPASS_EN
  input  logic              BYPASS,
`endif
  output logic              KEYED,
  output logic [CNT_W-1:0]  BEAT_CNT
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [LFSR_W-1:0] lfsr, lfsr_nx, lfsr_adv;
  logic [WIDTH-1:0]  out_data_nx;
  logic              out_vld_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              accept;
  logic              byp;

`ifdef XOR_STREAM_BYPASS_EN
  assign byp = BYPASS;
`else
  assign byp = 1'b0;
`endif

  assign KEYED  = (state == RUN);
  assign IN_RDY = KEYED && (!OUT_VLD || OUT_RDY);
  assign accept = IN_VLD && IN_RDY;

  always_comb begin
    lfsr_adv = lfsr >> 1;
    if (lfsr[0]) lfsr_adv = (lfsr >> 1) ^ TAPS;
  end

  always_comb begin
    state_nx    = state;
    lfsr_nx     = lfsr;
    out_data_nx = OUT_DATA;
    out_vld_nx  = OUT_VLD;
    cnt_nx      = BEAT_CNT;
    if (accept) begin
      out_data_nx = byp ? IN_DATA : (IN_DATA ^ lfsr[WIDTH-1:0]);
      out_vld_nx  = 1'b1;
      cnt_nx      = BEAT_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!byp) lfsr_nx = lfsr_adv;
    end else if (OUT_RDY) begin
      out_vld_nx = 1'b0;
    end
    // Seed load wins over the advance; the word accepted this cycle already used the old keystream.
    if (SEED_VLD) begin
      state_nx = RUN;
      lfsr_nx  = (SEED == '0) ? '1 : SEED;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      lfsr     <= '1;
      OUT_DATA <= '0;
      OUT_VLD  <= 1'b0;
      BEAT_CNT <= '0;
    end else begin
      state    <= state_nx;
      lfsr     <= lfsr_nx;
      OUT_DATA <= out_data_nx;
      OUT_VLD  <= out_vld_nx;
      BEAT_CNT <= cnt_nx;
    end
  end

endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
- Parametrised XOR stream-cipher datapath for the CRYPT pipeline: data word XOR keystream word, keystream from an internal Galois LFSR.
- Seeded through a load port; streaming valid/ready on both sides with a registered output stage.
- Symmetric: the same seed encrypts and decrypts.
- Sits between the byte source (UART/host side) and the downstream crypto/sink stage.

Parameters:
- WIDTH, 8, data and keystream word width; 1 ≤ WIDTH ≤ LFSR_W.
- LFSR_W, 16, LFSR state width.
- TAPS, 16'hB400, Galois feedback mask, LFSR_W bits wide (x^16+x^14+x^13+x^11+1).
- CNT_W, 16, beat counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- SEED  in  LFSR_W  LFSR seed value.
- SEED_VLD  in  1  one-cycle strobe; loads SEED.
- IN_DATA  in  WIDTH  plaintext or ciphertext word.
- IN_VLD  in  1  input word valid.
- IN_RDY  out  1  block accepts the input word.
- OUT_DATA  out  WIDTH  IN_DATA XOR keystream, registered.
- OUT_VLD  out  1  output word valid.
- OUT_RDY  in  1  downstream accepts the output word.
- KEYED  out  1  a seed has been loaded since reset.
- BEAT_CNT  out  CNT_W  words accepted since the last seed load.

Behaviour:
- Reset (async assert, released on the clock):
  - lfsr = all-ones, state = IDLE, KEYED = 0, OUT_VLD = 0, OUT_DATA = 0, BEAT_CNT = 0, IN_RDY = 0.
- States:
  - IDLE: no seed loaded; IN_RDY = 0; input words are not accepted.
  - RUN: entered on the first SEED_VLD; stays in RUN until reset.
  - KEYED = (state == RUN).
- Seed load on a SEED_VLD edge:
  - lfsr ← SEED; if SEED == 0, lfsr ← all-ones (avoids LFSR lockup).
  - BEAT_CNT ← 0.
- Handshake:
  - IN_RDY = KEYED && (!OUT_VLD || OUT_RDY), combinational.
  - Accept = IN_VLD && IN_RDY.
  - On accept: OUT_DATA ← IN_DATA ^ lfsr[WIDTH-1:0]; OUT_VLD ← 1; BEAT_CNT ← BEAT_CNT+1.
  - Latency: 1 cycle. Throughput: 1 word/cycle while OUT_RDY is held high.
- LFSR advance, once per accept:
  - If lfsr[0] == 1: lfsr ← (lfsr >> 1) ^ TAPS.
  - Otherwise: lfsr ← lfsr >> 1.
  - No advance on cycles without an accept.
- Output:
  - OUT_VLD clears when OUT_RDY is high and there is no accept in the same cycle.
  - OUT_DATA is held stable while OUT_VLD && !OUT_RDY (no change, no drop).
- Simultaneous SEED_VLD and accept:
  - The accepted word uses the pre-load keystream.
  - lfsr takes the seed (no advance).
  - BEAT_CNT ← 0; the new seed's stream starts with the next word.
- Seed load mid-stream: a pending OUT_DATA / OUT_VLD is unaffected.
- BEAT_CNT wraps from all-ones to 0 silently.
- IN_VLD in IDLE: ignored. IN_RDY stays 0; no state change.
- Reset mid-transfer: the pending output word is discarded; OUT_VLD = 0 immediately (async).

Optional Feature:
- Macro: XOR_STREAM_BYPASS_EN.
- When defined:
  - Adds input port BYPASS (1 bit).
  - An accept with BYPASS = 1 gives OUT_DATA ← IN_DATA unmodified.
  - The LFSR does not advance; BEAT_CNT still increments.
  - BYPASS is sampled only on the accept cycle.
- When undefined:
  - The port is absent and every accepted word is XORed.

Test Plan:
- Reset, then check outputs → OUT_VLD = 0, IN_RDY = 0, KEYED = 0, BEAT_CNT = 0. With IN_VLD = 1 for 5 cycles → no OUT_VLD.
- WIDTH = 8: SEED = 16'h0001, then stream 0xAA, 0x55, 0xFF with OUT_RDY = 1 → OUT_DATA 0xAB, 0x55, 0xFF, each 1 cycle after accept; BEAT_CNT = 3. Keystream is 0x01, 0x00, 0x00 (lfsr 0001 → B400 → 5A00).
- Reload SEED = 16'h0001 and feed 0xAB, 0x55, 0xFF → outputs 0xAA, 0x55, 0xFF (round-trip). SEED = 0 → behaves as seed 16'hFFFF: first keystream word 0xFF.
- Backpressure: hold OUT_RDY = 0 after the first accept → IN_RDY = 0, OUT_DATA held, lfsr frozen. Release OUT_RDY → the next word uses the second keystream value; no words lost or duplicated.
- SEED_VLD in the same cycle as an accept → that word uses the old keystream, the next word uses the new seed's first word, BEAT_CNT = 0 then 1. Also assert RST while OUT_VLD = 1 → OUT_VLD drops at once and KEYED = 0.
- With XOR_STREAM_BYPASS_EN: SEED = 16'h0001, then words 0x12 (BYPASS = 1) and 0x34 (BYPASS = 0) → outputs 0x12 and 0x35; BEAT_CNT = 2.
